// File: rtl/sha256_msg_sched.sv
// SHA-256 message schedule: loads a 16-word block, expands W[16..ROUNDS-1] one word per cycle,
// then holds the finished array on a valid/ready handshake until the consumer takes it.
module sha256_msg_sched #(
    parameter int ROUNDS = 64
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     blk_valid,
    output logic                     blk_ready,
    input  logic [0:15][31:0]        blk_data,
    output logic                     w_valid,
    input  logic                     w_ready,
    output logic [0:ROUNDS-1][31:0]  W,
    output logic                     busy,
    output logic [6:0]               idx
);

    localparam int IW = $clog2(ROUNDS);

    typedef enum logic [1:0] {IDLE, EXPAND, HOLD} state_t;

    state_t                     state_q;
    logic [6:0]                 idx_q;
    logic [0:ROUNDS-1][31:0]    w_q;
    logic                       blk_ready_q;
    logic                       w_valid_q;
    logic                       busy_q;

    logic [IW-1:0]              iw;
    logic [IW-1:0]              i2;
    logic [IW-1:0]              i7;
    logic [IW-1:0]              i15;
    logic [IW-1:0]              i16;
    logic [31:0]                w_new_d;

    function automatic logic [31:0] sig0(input logic [31:0] x);
        return {x[6:0], x[31:7]} ^ {x[17:0], x[31:18]} ^ (x >> 3);
    endfunction

    function automatic logic [31:0] sig1(input logic [31:0] x);
        return {x[16:0], x[31:17]} ^ {x[18:0], x[31:19]} ^ (x >> 10);
    endfunction

    // All operands are read from registered W; outside EXPAND the result is simply unused.
    always_comb begin
        iw      = idx_q[IW-1:0];
        i2      = iw - IW'(2);
        i7      = iw - IW'(7);
        i15     = iw - IW'(15);
        i16     = iw - IW'(16);
        w_new_d = sig1(w_q[i2]) + w_q[i7] + sig0(w_q[i15]) + w_q[i16];
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            idx_q       <= 7'd16;
            w_q         <= '0;
            blk_ready_q <= 1'b1;
            w_valid_q   <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (blk_valid) begin
                        w_q[0:15]   <= blk_data;
                        idx_q       <= 7'd16;
                        state_q     <= EXPAND;
                        blk_ready_q <= 1'b0;
                        busy_q      <= 1'b1;
                    end
                end
                EXPAND: begin
                    w_q[iw] <= w_new_d;
                    idx_q   <= idx_q + 7'd1;
                    if (idx_q == 7'(ROUNDS - 1)) begin
                        state_q   <= HOLD;
                        w_valid_q <= 1'b1;
                    end
                end
                HOLD: begin
                    // Return to IDLE only; the next block is accepted on the following cycle.
                    if (w_ready) begin
                        state_q     <= IDLE;
                        w_valid_q   <= 1'b0;
                        busy_q      <= 1'b0;
                        blk_ready_q <= 1'b1;
                    end
                end
                default: begin
                    state_q     <= IDLE;
                    blk_ready_q <= 1'b1;
                    w_valid_q   <= 1'b0;
                    busy_q      <= 1'b0;
                end
            endcase
        end
    end

    assign blk_ready = blk_ready_q;
    assign w_valid   = w_valid_q;
    assign busy      = busy_q;
    assign idx       = idx_q;
    assign W         = w_q;

endmodule

// File: tb/tb_sha256_msg_sched.sv
// Directed bench for sha256_msg_sched: golden schedule model feeds a scoreboard queue,
// plus a reference compression round to confirm the "abc" digest end to end.
module tb_sha256_msg_sched;

    typedef logic [0:15][31:0] blk_t;
    typedef logic [0:63][31:0] warr_t;

    logic        clk;
    logic        reset;
    logic        blk_valid;
    logic        blk_ready;
    blk_t        blk_data;
    logic        w_valid;
    logic        w_ready;
    warr_t       W;
    logic        busy;
    logic [6:0]  idx;

    int checks = 0;
    int errors = 0;
    warr_t exp_q[$];

    localparam logic [31:0] K [0:63] = '{
        32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
        32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
        32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
        32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
        32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
        32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
        32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
        32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
    };
    localparam logic [31:0] IV [0:7] = '{
        32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
        32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19
    };

    sha256_msg_sched #(.ROUNDS(64)) dut (
        .clk       (clk),
        .reset     (reset),
        .blk_valid (blk_valid),
        .blk_ready (blk_ready),
        .blk_data  (blk_data),
        .w_valid   (w_valid),
        .w_ready   (w_ready),
        .W         (W),
        .busy      (busy),
        .idx       (idx)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic [31:0] ror(input logic [31:0] x, input int n);
        return (x >> n) | (x << (32 - n));
    endfunction

    function automatic warr_t expand(input blk_t b);
        warr_t w;
        w = '0;
        for (int i = 0; i < 16; i++) w[i] = b[i];
        for (int i = 16; i < 64; i++)
            w[i] = (ror(w[i-2], 17) ^ ror(w[i-2], 19) ^ (w[i-2] >> 10)) + w[i-7]
                 + (ror(w[i-15], 7) ^ ror(w[i-15], 18) ^ (w[i-15] >> 3)) + w[i-16];
        return w;
    endfunction

    function automatic logic [255:0] compress(input warr_t w);
        logic [31:0] a, b, c, d, e, f, g, h, t1, t2;
        a = IV[0]; b = IV[1]; c = IV[2]; d = IV[3];
        e = IV[4]; f = IV[5]; g = IV[6]; h = IV[7];
        for (int t = 0; t < 64; t++) begin
            t1 = h + (ror(e, 6) ^ ror(e, 11) ^ ror(e, 25)) + ((e & f) ^ (~e & g)) + K[t] + w[t];
            t2 = (ror(a, 2) ^ ror(a, 13) ^ ror(a, 22)) + ((a & b) ^ (a & c) ^ (b & c));
            h = g; g = f; f = e; e = d + t1;
            d = c; c = b; b = a; a = t1 + t2;
        end
        return {a + IV[0], b + IV[1], c + IV[2], d + IV[3],
                e + IV[4], f + IV[5], g + IV[6], h + IV[7]};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_w(input string tag, input warr_t obs, input warr_t exp);
        int bad;
        checks++;
        assert (obs === exp) else begin
            errors++;
            bad = 0;
            for (int i = 63; i >= 0; i--) if (obs[i] !== exp[i]) bad = i;
            $error("FAIL %s: W[%0d] observed %h expected %h", tag, bad, obs[bad], exp[bad]);
        end
    endtask

    task automatic sb_check(input string tag);
        warr_t e;
        if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $error("FAIL %s: observed output with empty scoreboard expected a queued block", tag);
        end else begin
            e = exp_q.pop_front();
            chk_w(tag, W, e);
        end
    endtask

    // Drives one block and returns once the accept edge has passed.
    task automatic send(input blk_t b, input bit keep_valid);
        int g;
        blk_data  = b;
        blk_valid = 1'b1;
        g = 0;
        while (!blk_ready && g < 200) begin tick(); g++; end
        chk("accept_wait", 256'(g < 200), 256'(1));
        tick();
        exp_q.push_back(expand(b));
        if (!keep_valid) blk_valid = 1'b0;
    endtask

    task automatic wait_wvalid(output int n);
        n = 0;
        while (!w_valid && n < 200) begin tick(); n++; end
    endtask

    initial begin
        blk_t  abc, blk, rnd;
        warr_t snap;
        int    n, m;

        abc = '0;
        abc[0]  = 32'h61626380;
        abc[15] = 32'h00000018;

        reset = 1'b1; blk_valid = 1'b0; blk_data = '0; w_ready = 1'b0;
        tick(); tick(); tick();
        reset = 1'b0;
        chk("rst_blk_ready", 256'(blk_ready), 256'(1));
        chk("rst_w_valid",   256'(w_valid),   256'(0));
        chk("rst_busy",      256'(busy),      256'(0));
        chk("rst_idx",       256'(idx),       256'(16));
        chk_w("rst_W", W, '0);

        // "abc" block with immediate acceptance of the result
        w_ready = 1'b1;
        send(abc, 1'b0);
        chk("abc_busy", 256'(busy), 256'(1));
        chk("abc_blk_ready_low", 256'(blk_ready), 256'(0));
        wait_wvalid(n);
        chk("abc_latency", 256'(n), 256'(48));
        chk("abc_idx_sat", 256'(idx), 256'(64));
        chk("abc_W16", 256'(W[16]), 256'(32'h61626380));
        chk("abc_W17", 256'(W[17]), 256'(32'h000F0000));
        chk("abc_W18", 256'(W[18]), 256'(32'h7DA86405));
        chk("abc_W19", 256'(W[19]), 256'(32'h600003C6));
        chk("abc_digest", compress(W),
            256'hba7816bf_8f01cfea_414140de_5dae2223_b00361a3_96177a9c_b410ff61_f20015ad);
        sb_check("abc_W");
        tick();
        chk("abc_handoff_w_valid", 256'(w_valid), 256'(0));
        chk("abc_handoff_blk_ready", 256'(blk_ready), 256'(1));

        // all-zero and all-ones blocks
        send('0, 1'b0);
        wait_wvalid(n);
        chk("zero_latency", 256'(n), 256'(48));
        chk_w("zero_W", W, '0);
        sb_check("zero_sb");
        tick();
        send('1, 1'b0);
        wait_wvalid(n);
        chk("ones_latency", 256'(n), 256'(48));
        sb_check("ones_W");
        tick();

        // backpressure in HOLD while upstream keeps toggling
        w_ready = 1'b0;
        blk = '0;
        for (int i = 0; i < 16; i++) blk[i] = $urandom;
        send(blk, 1'b0);
        wait_wvalid(n);
        chk("bp_latency", 256'(n), 256'(48));
        snap = W;
        for (int c = 0; c < 20; c++) begin
            for (int i = 0; i < 16; i++) rnd[i] = $urandom;
            blk_data  = rnd;
            blk_valid = c[0];
            tick();
            chk_w("bp_W_stable", W, snap);
            chk("bp_blk_ready", 256'(blk_ready), 256'(0));
            chk("bp_w_valid", 256'(w_valid), 256'(1));
        end
        blk_valid = 1'b0;
        sb_check("bp_W");
        w_ready = 1'b1;
        tick();
        w_ready = 1'b0;
        chk("bp_release_w_valid", 256'(w_valid), 256'(0));
        chk("bp_release_blk_ready", 256'(blk_ready), 256'(1));
        tick();
        chk("bp_no_accept", 256'(busy), 256'(0));

        // back-to-back blocks with blk_valid held high
        w_ready = 1'b1;
        for (int i = 0; i < 16; i++) blk[i] = $urandom;
        send(blk, 1'b1);
        for (int i = 0; i < 16; i++) rnd[i] = $urandom;
        blk_data = rnd;
        wait_wvalid(n);
        chk("b2b_first_latency", 256'(n), 256'(48));
        sb_check("b2b_first_W");
        m = 0;
        while (!blk_ready && m < 10) begin tick(); m++; end
        chk("b2b_blk_ready_delay", 256'(m), 256'(1));
        exp_q.push_back(expand(rnd));
        tick();
        blk_valid = 1'b0;
        blk_data  = '0;
        chk("b2b_period", 256'(n + m + 1), 256'(50));
        chk("b2b_second_busy", 256'(busy), 256'(1));
        wait_wvalid(n);
        chk("b2b_second_latency", 256'(n), 256'(48));
        sb_check("b2b_second_W");
        tick();

        // reset in the middle of expansion
        send(abc, 1'b0);
        n = 0;
        while (idx != 7'd30 && n < 100) begin tick(); n++; end
        chk("mid_idx_reached", 256'(idx), 256'(30));
        reset = 1'b1;
        tick();
        reset = 1'b0;
        void'(exp_q.pop_back());
        chk("mid_rst_w_valid",   256'(w_valid),   256'(0));
        chk("mid_rst_blk_ready", 256'(blk_ready), 256'(1));
        chk("mid_rst_busy",      256'(busy),      256'(0));
        chk("mid_rst_idx",       256'(idx),       256'(16));
        chk_w("mid_rst_W", W, '0);
        send(abc, 1'b0);
        wait_wvalid(n);
        chk("mid_abc_latency", 256'(n), 256'(48));
        chk("mid_abc_digest", compress(W),
            256'hba7816bf_8f01cfea_414140de_5dae2223_b00361a3_96177a9c_b410ff61_f20015ad);
        sb_check("mid_abc_W");
        tick();
        chk("final_queue_empty", 256'(exp_q.size()), 256'(0));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
